// File: rtl/vram_cmd_pkg.sv
// rtl/vram_cmd_pkg.sv - opcodes, FSM states and length width for vram_cmd_ctrl; fill states exist only with VRAM_CMD_FILL_EN
package vram_cmd_pkg;

    localparam int LEN_W = 16;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_SET_ADDR = 8'h01;
    localparam logic [7:0] OP_WRITE    = 8'h02;
    localparam logic [7:0] OP_FILL     = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA
`ifdef VRAM_CMD_FILL_EN
        ,
        S_FILL_VAL,
        S_FILL_RUN
`endif
    } state_t;

endpackage

// File: rtl/rx_byte_latch.sv
// rtl/rx_byte_latch.sv - rx_ready edge detect, rx_ack pulse, 1-deep pending byte latch and overrun flag
module rx_byte_latch (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       consume,
    output logic       rx_ack,
    output logic       pending_valid,
    output logic [7:0] pending_data,
    output logic       overrun,
    output logic       activity
);

    logic rx_ready_q;
    logic capture;

    assign capture = rx_ready & ~rx_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_q    <= 1'b0;
            rx_ack        <= 1'b0;
            pending_valid <= 1'b0;
            pending_data  <= '0;
            overrun       <= 1'b0;
            activity      <= 1'b0;
        end else begin
            rx_ready_q <= rx_ready;
            rx_ack     <= capture;
            // a byte freed by the FSM on the same edge is not lost
            overrun    <= capture & pending_valid & ~consume;
            if (capture) begin
                pending_data  <= rx_data;
                pending_valid <= 1'b1;
                activity      <= ~activity;
            end else if (consume) begin
                pending_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vram_cmd_ctrl.sv
// rtl/vram_cmd_ctrl.sv - VRAM user-port command sequencer (set address, write burst; fill with VRAM_CMD_FILL_EN)
module vram_cmd_ctrl
    import vram_cmd_pkg::*;
#(
    parameter int DEPTH  = 22500,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              rx_ack,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    output logic              busy,
    output logic              err,
    output logic              activity
);

    localparam logic [LEN_W-1:0]  DEPTH_W   = LEN_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        hi_byte;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  word;
    logic              pending_valid;
    logic [7:0]        pending_data;
    logic              overrun;
    logic              consume;
    logic              wr_fire;
    logic [7:0]        wr_byte;
`ifdef VRAM_CMD_FILL_EN
    logic              is_fill;
    logic [7:0]        fill_val;
`endif

    rx_byte_latch u_latch (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .consume       (consume),
        .rx_ack        (rx_ack),
        .pending_valid (pending_valid),
        .pending_data  (pending_data),
        .overrun       (overrun),
        .activity      (activity)
    );

    assign word = {hi_byte, pending_data};

`ifdef VRAM_CMD_FILL_EN
    assign consume = pending_valid && (state != S_FILL_RUN);
`else
    assign consume = pending_valid;
`endif

    always_comb begin
        wr_fire = 1'b0;
        wr_byte = pending_data;
        case (state)
            S_DATA:     wr_fire = consume;
`ifdef VRAM_CMD_FILL_EN
            S_FILL_VAL: wr_fire = consume;
            S_FILL_RUN: begin
                wr_fire = 1'b1;
                wr_byte = fill_val;
            end
`endif
            default:    wr_fire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr       <= '0;
            hi_byte    <= '0;
            remaining  <= '0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
`ifdef VRAM_CMD_FILL_EN
            is_fill    <= 1'b0;
            fill_val   <= '0;
`endif
        end else begin
            vram_we <= wr_fire;
            // the final write of a burst or fill also retires the command
            if (wr_fire) begin
                vram_addr  <= addr;
                vram_wdata <= wr_byte;
                addr       <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                remaining  <= remaining - 1'b1;
                if (remaining == LEN_W'(1)) state <= S_IDLE;
            end
            if (overrun) err <= 1'b1;

            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (consume) begin
                        case (pending_data)
                            OP_NOP: ;
                            OP_SET_ADDR: begin
                                state <= S_ADDR_HI;
                                busy  <= 1'b1;
                            end
                            OP_WRITE: begin
`ifdef VRAM_CMD_FILL_EN
                                is_fill <= 1'b0;
`endif
                                state <= S_LEN_HI;
                                busy  <= 1'b1;
                            end
`ifdef VRAM_CMD_FILL_EN
                            OP_FILL: begin
                                is_fill <= 1'b1;
                                state   <= S_LEN_HI;
                                busy    <= 1'b1;
                            end
`endif
                            default: err <= 1'b1;
                        endcase
                    end
                end
                S_ADDR_HI: if (consume) begin
                    hi_byte <= pending_data;
                    state   <= S_ADDR_LO;
                end
                S_ADDR_LO: if (consume) begin
                    if (word >= DEPTH_W) begin
                        addr <= '0;
                        err  <= 1'b1;
                    end else begin
                        addr <= word[ADDR_W-1:0];
                    end
                    state <= S_IDLE;
                end
                S_LEN_HI: if (consume) begin
                    hi_byte <= pending_data;
                    state   <= S_LEN_LO;
                end
                S_LEN_LO: if (consume) begin
                    remaining <= word;
                    if (word == '0) begin
                        state <= S_IDLE;
                    end else begin
`ifdef VRAM_CMD_FILL_EN
                        state <= is_fill ? S_FILL_VAL : S_DATA;
`else
                        state <= S_DATA;
`endif
                    end
                end
`ifdef VRAM_CMD_FILL_EN
                S_FILL_VAL: if (consume) begin
                    fill_val <= pending_data;
                    if (remaining != LEN_W'(1)) state <= S_FILL_RUN;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_cmd_ctrl.sv
// tb/tb_vram_cmd_ctrl.sv - randomized self-checking bench for vram_cmd_ctrl against a transaction-level write model
module tb_vram_cmd_ctrl;

    localparam int DEPTH  = 22500;
    localparam int ADDR_W = 15;

    typedef struct {
        int a;
        int d;
    } wr_t;

    typedef struct {
        int a;
        int d;
        int c;
    } log_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready = 1'b0;
    logic              rx_ack;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_wdata;
    logic              busy;
    logic              err;
    logic              activity;

    vram_cmd_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .rx_ack     (rx_ack),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .busy       (busy),
        .err        (err),
        .activity   (activity)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   wr_count = 0;
    int   sent_cnt = 0;
    int   last_cap = 0;
    int   m_addr = 0;
    int   m_err = 0;
    wr_t  exp_q[$];
    log_t wlog[$];
    int   payload[$];
    wr_t  cmp_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // every user-port write must be the next one the model predicts
    always @(negedge clk) begin
        if (rst_n && vram_we) begin
            wr_count++;
            wlog.push_back('{int'(vram_addr), int'(vram_wdata), cyc});
            chk("busy_during_write", int'(busy), 1);
            chk("write_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                cmp_e = exp_q.pop_front();
                chk("write_addr", int'(vram_addr), cmp_e.a);
                chk("write_data", int'(vram_wdata), cmp_e.d);
            end
        end
    end

    task automatic m_write_byte(input int d);
        exp_q.push_back('{m_addr, d});
        m_addr = (m_addr + 1) % DEPTH;
    endtask

    task automatic send_byte(input int b);
        @(posedge clk);
        #1;
        rx_data  = b[7:0];
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        last_cap = cyc;
        sent_cnt++;
        chk("rx_ack", int'(rx_ack), 1);
        chk("activity", int'(activity), sent_cnt % 2);
        rx_ready = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (3) @(posedge clk);
        #1;
        while (busy && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rx_ack"}, int'(rx_ack), 0);
        chk({tag, "_vram_we"}, int'(vram_we), 0);
        chk({tag, "_vram_addr"}, int'(vram_addr), 0);
        chk({tag, "_vram_wdata"}, int'(vram_wdata), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_activity"}, int'(activity), 0);
    endtask

    task automatic do_reset(input string tag);
        rx_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero(tag);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_addr = 0;
        m_err = 0;
        sent_cnt = 0;
        exp_q.delete();
        wlog.delete();
    endtask

    task automatic cmd_set_addr(input int v);
        if (v >= DEPTH) begin
            m_err = 1;
            m_addr = 0;
        end else begin
            m_addr = v;
        end
        send_byte(1);
        send_byte((v >> 8) & 255);
        send_byte(v & 255);
    endtask

    task automatic cmd_write();
        int len;
        len = payload.size();
        foreach (payload[i]) m_write_byte(payload[i]);
        send_byte(2);
        send_byte((len >> 8) & 255);
        send_byte(len & 255);
        foreach (payload[i]) send_byte(payload[i]);
    endtask

    task automatic cmd_fill(input int len, input int v);
        for (int i = 0; i < len; i++) m_write_byte(v);
        send_byte(3);
        send_byte((len >> 8) & 255);
        send_byte(len & 255);
        send_byte(v);
    endtask

    task automatic chk_log(input string name, input int idx, input int a, input int d);
        chk({name, "_present"}, int'(wlog.size() > idx), 1);
        if (wlog.size() > idx) begin
            chk({name, "_addr"}, wlog[idx].a, a);
            chk({name, "_data"}, wlog[idx].d, d);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int cap_cc;
        int vcap;
        int n;
        int wcnt;
        int k;

        do_reset("reset");

        // explicit address then a three-byte burst
        cmd_set_addr(16'h0010);
        payload = {};
        payload.push_back(8'hAA);
        payload.push_back(8'hBB);
        payload.push_back(8'hCC);
        cmd_write();
        cap_cc = last_cap;
        wait_idle();
        chk("t1_count", wlog.size(), 3);
        chk_log("t1_w0", 0, 16, 8'hAA);
        chk_log("t1_w1", 1, 17, 8'hBB);
        chk_log("t1_w2", 2, 18, 8'hCC);
        if (wlog.size() == 3) chk("t1_latency", wlog[2].c, cap_cc + 1);
        chk("t1_err", int'(err), 0);

        // burst across the top of the address space
        wlog.delete();
        cmd_set_addr(22499);
        payload = {};
        payload.push_back(8'h11);
        payload.push_back(8'h22);
        cmd_write();
        wait_idle();
        chk_log("wrap_w0", 0, 22499, 8'h11);
        chk_log("wrap_w1", 1, 0, 8'h22);
        chk("wrap_err", int'(err), 0);

        // random legal traffic
        do_reset("rand_rst");
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 3);
            if (k == 0) begin
                send_byte(0);
            end else if (k == 1) begin
                if ($urandom_range(0, 1) == 1) cmd_set_addr($urandom_range(DEPTH - 6, DEPTH - 1));
                else cmd_set_addr($urandom_range(0, DEPTH - 1));
            end else begin
`ifdef VRAM_CMD_FILL_EN
                if (k == 3) begin
                    cmd_fill($urandom_range(1, 12), $urandom_range(0, 255));
                end else begin
`endif
                    payload = {};
                    n = $urandom_range(0, 6);
                    for (int j = 0; j < n; j++) payload.push_back($urandom_range(0, 255));
                    cmd_write();
`ifdef VRAM_CMD_FILL_EN
                end
`endif
            end
            wait_idle();
            chk("rand_err", int'(err), m_err);
        end
        chk("rand_drained", exp_q.size(), 0);

`ifdef VRAM_CMD_FILL_EN
        // fill of five, then a command byte held across a fill
        do_reset("fill_rst");
        cmd_set_addr(0);
        cmd_fill(5, 8'h7F);
        vcap = last_cap;
        wait_idle();
        chk("fill_count", wlog.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk_log("fill_w", i, i, 8'h7F);
            if (wlog.size() > i) chk("fill_cycle", wlog[i].c, vcap + 1 + i);
        end
        cmd_fill(10, 8'h5A);
        send_byte(1);
        wait_idle();
        send_byte(0);
        send_byte(8'h20);
        m_addr = 16'h20;
        wlog.delete();
        payload = {};
        payload.push_back(8'h99);
        cmd_write();
        wait_idle();
        chk_log("held_w", 0, 16'h20, 8'h99);
        chk("held_err", int'(err), 0);

        // two bytes with no consumption in between overrun the latch
        do_reset("ovr_rst");
        cmd_fill(256, 8'h33);
        send_byte(0);
        chk("ovr_first_ok", int'(err), 0);
        send_byte(0);
        m_err = 1;
        wait_idle();
        chk("ovr_err", int'(err), 1);
        chk("ovr_drained", exp_q.size(), 0);
`else
        do_reset("nofill_rst");
        send_byte(3);
        m_err = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("nofill_err", int'(err), 1);
        chk("nofill_busy", int'(busy), 0);
        payload = {};
        payload.push_back(8'h55);
        cmd_write();
        wait_idle();
        chk_log("nofill_w", 0, 0, 8'h55);
`endif

        // unknown opcode
        do_reset("unk_rst");
        send_byte(5);
        repeat (3) @(posedge clk);
        #1;
        chk("unk_err", int'(err), 1);
        chk("unk_busy", int'(busy), 0);

        // out-of-range address loads 0
        do_reset("badaddr_rst");
        cmd_set_addr(16'h6000);
        wait_idle();
        chk("badaddr_err", int'(err), 1);
        chk("badaddr_nowrite", wlog.size(), 0);
        payload = {};
        payload.push_back(8'h44);
        cmd_write();
        wait_idle();
        chk_log("badaddr_w", 0, 0, 8'h44);

        // reset after the first of three burst bytes
        do_reset("mid_rst");
        cmd_set_addr(16'h0010);
        send_byte(2);
        send_byte(0);
        send_byte(3);
        m_write_byte(8'hAA);
        send_byte(8'hAA);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_first_write", exp_q.size(), 0);
        wcnt = wr_count;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_in_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_addr = 0;
        m_err = 0;
        sent_cnt = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_no_more_writes", wr_count, wcnt);
        chk("mid_busy", int'(busy), 0);
        chk("mid_err", int'(err), 0);

        chk("final_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
